// File: rtl/sy_ppl_flush_arb.sv
// sy_ppl_flush_arb: round-robin arbiter sequencing D$ -> I$ -> TLB flushes for NREQ requesters.
// Optional D$ ack timeout (err_o) is built when SY_FLUSH_TIMEOUT_EN is defined.
module sy_ppl_flush_arb #(
  parameter int NREQ   = 2,
  parameter int TO_CYC = 1024
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [NREQ-1:0] req_valid_i,
  input  logic [NREQ-1:0] req_dc_i,
  input  logic [NREQ-1:0] req_ic_i,
  input  logic [NREQ-1:0] req_tlb_i,
  output logic [NREQ-1:0] done_o,
  output logic            err_o,
  output logic            busy_o,
  output logic            ppl_dcache_flush_o,
  input  logic            ppl_dcache_flush_ack_i,
  output logic            ppl_icache_flush_o,
  output logic            ppl_tlb_flush_o
);
  localparam int GW = NREQ > 1 ? $clog2(NREQ) : 1;
  typedef enum logic [2:0] {IDLE, DC, IC, TLB, DONE} state_t;
  state_t state_q, state_d;
  logic [GW-1:0] gnt_q, gnt_d, rr_q, rr_d, sel;
  logic dc_q, dc_d, ic_q, ic_d, tlb_q, tlb_d, found;
`ifdef SY_FLUSH_TIMEOUT_EN
  localparam int CW = $clog2(TO_CYC);
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
`else
  logic unused_to;
  assign unused_to = TO_CYC < 2;
`endif
  // first valid requester at or after the round-robin pointer
  always_comb begin
    int k;
    k = 0;
    found = 1'b0;
    sel = '0;
    for (int j = 0; j < NREQ; j++) begin
      k = (int'(rr_q) + j) % NREQ;
      if (!found && req_valid_i[k]) begin
        found = 1'b1;
        sel = GW'(k);
      end
    end
  end
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    rr_d = rr_q;
    dc_d = dc_q;
    ic_d = ic_q;
    tlb_d = tlb_q;
`ifdef SY_FLUSH_TIMEOUT_EN
    cnt_d = cnt_q;
    err_d = err_q;
`endif
    case (state_q)
      IDLE: if (found) begin
        gnt_d = sel;
        dc_d = req_dc_i[sel];
        ic_d = req_ic_i[sel];
        tlb_d = req_tlb_i[sel];
        rr_d = sel == GW'(NREQ - 1) ? '0 : sel + 1'b1;
        state_d = req_dc_i[sel] ? DC : req_ic_i[sel] ? IC : req_tlb_i[sel] ? TLB : DONE;
`ifdef SY_FLUSH_TIMEOUT_EN
        cnt_d = '0;
        err_d = 1'b0;
`endif
      end
      DC: if (ppl_dcache_flush_ack_i) state_d = ic_q ? IC : tlb_q ? TLB : DONE;
`ifdef SY_FLUSH_TIMEOUT_EN
      else if (cnt_q == CW'(TO_CYC - 1)) begin
        state_d = DONE;
        err_d = 1'b1;
      end else cnt_d = cnt_q + 1'b1;
`endif
      IC: state_d = tlb_q ? TLB : DONE;
      TLB: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      gnt_q <= '0;
      rr_q <= '0;
      dc_q <= 1'b0;
      ic_q <= 1'b0;
      tlb_q <= 1'b0;
`ifdef SY_FLUSH_TIMEOUT_EN
      cnt_q <= '0;
      err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      rr_q <= rr_d;
      dc_q <= dc_d;
      ic_q <= ic_d;
      tlb_q <= tlb_d;
`ifdef SY_FLUSH_TIMEOUT_EN
      cnt_q <= cnt_d;
      err_q <= err_d;
`endif
    end
  end
  assign busy_o = state_q != IDLE;
  assign ppl_dcache_flush_o = state_q == DC && dc_q;
  assign ppl_icache_flush_o = state_q == IC;
  assign ppl_tlb_flush_o = state_q == TLB;
  assign done_o = state_q == DONE ? NREQ'(1) << gnt_q : '0;
`ifdef SY_FLUSH_TIMEOUT_EN
  assign err_o = state_q == DONE && err_q;
`else
  assign err_o = 1'b0;
`endif
endmodule

// File: tb/tb_sy_ppl_flush_arb.sv
// tb_sy_ppl_flush_arb: directed checks of sy_ppl_flush_arb output vectors cycle by cycle.
module tb_sy_ppl_flush_arb;
  logic clk_i = 1'b0, rst_i = 1'b0, ack = 1'b0;
  logic [1:0] vld = '0, rdc = '0, ric = '0, rtlb = '0, done;
  logic err, busy, dcf, icf, tlbf;
  int n_cmp = 0, n_err = 0;
  sy_ppl_flush_arb #(.NREQ(2), .TO_CYC(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(vld), .req_dc_i(rdc), .req_ic_i(ric),
    .req_tlb_i(rtlb), .done_o(done), .err_o(err), .busy_o(busy),
    .ppl_dcache_flush_o(dcf), .ppl_dcache_flush_ack_i(ack),
    .ppl_icache_flush_o(icf), .ppl_tlb_flush_o(tlbf)
  );
  always #5 clk_i = ~clk_i;
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  // vector layout: {err, busy, dcache, icache, tlb, done[1:0]}
  task automatic chk(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    obs = {err, busy, dcf, icf, tlbf, done};
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  initial begin
    #2 chk("reset", 7'b0000000);
    tick();
    rst_i = 1'b1;
    tick();
    chk("idle", 7'b0000000);
    ack = 1'b1;
    tick();
    chk("ack_idle_ignored", 7'b0000000);
    ack = 1'b0;
    vld = 2'b01; rdc = 2'b01;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 4) ack = 1'b1;
      chk($sformatf("dc_only_c%0d", c), 7'b0110000);
    end
    tick();
    ack = 1'b0; vld = 2'b00;
    chk("dc_only_done", 7'b0100001);
    tick();
    chk("dc_only_idle", 7'b0000000);
    vld = 2'b01; rdc = 2'b01; ric = 2'b01; rtlb = 2'b01;
    tick();
    chk("all_c1_dc", 7'b0110000);
    tick();
    ack = 1'b1;
    chk("all_c2_dc", 7'b0110000);
    rdc = 2'b00; ric = 2'b00; rtlb = 2'b00;
    tick();
    ack = 1'b0;
    chk("all_c3_ic", 7'b0101000);
    tick();
    chk("all_c4_tlb", 7'b0100100);
    tick();
    vld = 2'b00;
    chk("all_c5_done", 7'b0100001);
    tick();
    chk("all_idle", 7'b0000000);
    vld = 2'b10;
    tick();
    vld = 2'b00;
    chk("none_done", 7'b0100010);
    tick();
    chk("none_idle", 7'b0000000);
    vld = 2'b11; ric = 2'b11;
    tick(); chk("rr_c1_ic", 7'b0101000);
    tick(); chk("rr_c2_done0", 7'b0100001);
    tick(); chk("rr_c3_idle", 7'b0000000);
    tick(); chk("rr_c4_ic", 7'b0101000);
    tick(); chk("rr_c5_done1", 7'b0100010);
    tick(); chk("rr_c6_idle", 7'b0000000);
    tick(); chk("rr_c7_ic", 7'b0101000);
    tick();
    vld = 2'b00; ric = 2'b00;
    chk("rr_c8_done0", 7'b0100001);
    tick();
    chk("rr_idle", 7'b0000000);
    vld = 2'b01; rdc = 2'b01;
    tick(); chk("rst_c1_dc", 7'b0110000);
    tick(); chk("rst_c2_dc", 7'b0110000);
    tick(); chk("rst_c3_dc", 7'b0110000);
    rst_i = 1'b0;
    #1 chk("rst_async", 7'b0000000);
    tick();
    rst_i = 1'b1;
    vld = 2'b11; rdc = 2'b00; rtlb = 2'b11;
    tick(); chk("post_rst_tlb", 7'b0100100);
    tick();
    vld = 2'b00; rtlb = 2'b00;
    chk("post_rst_done0", 7'b0100001);
    tick();
    chk("post_rst_idle", 7'b0000000);
`ifdef SY_FLUSH_TIMEOUT_EN
    vld = 2'b01; rdc = 2'b01; ric = 2'b01;
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk($sformatf("to_c%0d_dc", c), 7'b0110000);
    end
    tick();
    vld = 2'b00; rdc = 2'b00; ric = 2'b00;
    chk("to_done_err", 7'b1100001);
    tick();
    ack = 1'b1;
    chk("to_idle", 7'b0000000);
    tick();
    ack = 1'b0;
    chk("to_late_ack", 7'b0000000);
`else
    vld = 2'b01; rdc = 2'b01;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 12) ack = 1'b1;
      chk($sformatf("wait_c%0d_dc", c), 7'b0110000);
    end
    tick();
    ack = 1'b0; vld = 2'b00; rdc = 2'b00;
    chk("wait_done_noerr", 7'b0100001);
    tick();
    chk("wait_idle", 7'b0000000);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sy_ppl_flush_arb.md
# sy_ppl_flush_arb

Arbiter and sequencer sharing the cache/TLB maintenance datapath (D$ writeback-invalidate, I$ invalidate, TLB flush) between up to NREQ requesters, e.g. the pipeline controller (fence, fence.i, sfence.vma) and the debug module. It sits between the requesters and the IMEM/DMEM flush ports. It grants one requester at a time, round-robin. It issues that requester's flush operations in the fixed order D$ → I$ → TLB, then returns a one-cycle done pulse.

## Interface
- NREQ, 2: number of requesters, 1..8.
- TO_CYC, 1024: D$ ack timeout in cycles, ≥2. Used only when the timeout feature is compiled in.
- clk_i  in  1  core clock.
- rst_i  in  1  reset; asynchronous, active-low.
- req_valid_i  in  NREQ  per-requester request. Held high until the matching done_o bit pulses.
- req_dc_i  in  NREQ  request D$ writeback+invalidate. Sampled at grant.
- req_ic_i  in  NREQ  request I$ invalidate. Sampled at grant.
- req_tlb_i  in  NREQ  request TLB flush. Sampled at grant.
- done_o  out  NREQ  one-cycle completion pulse to the granted requester.
- err_o  out  1  one-cycle pulse, coincident with done_o, when the D$ flush timed out.
- busy_o  out  1  high whenever state ≠ IDLE.
- ppl_dcache_flush_o  out  1  D$ flush request. Held until ack.
- ppl_dcache_flush_ack_i  in  1  D$ flush complete. Single-cycle pulse.
- ppl_icache_flush_o  out  1  I$ invalidate pulse.
- ppl_tlb_flush_o  out  1  TLB flush pulse.

## Operation
- States: IDLE, DC, IC, TLB, DONE. State, grant index (gnt_q), latched type bits (dc_q, ic_q, tlb_q), round-robin pointer (rr_q) and timeout counter are all registers.
- IDLE: when any req_valid_i bit is set, select the first set bit at or after rr_q, wrapping modulo NREQ.
  - Latch the selected requester's index and type bits.
  - Set rr_q = (gnt+1) mod NREQ.
  - Next state is the first of DC/IC/TLB whose latched bit is set; DONE if none are set.
- DC: ppl_dcache_flush_o = 1. On ack, go to IC if ic_q, else TLB if tlb_q, else DONE. Otherwise stay in DC.
- IC: ppl_icache_flush_o = 1 for exactly one cycle. Next is TLB if tlb_q, else DONE.
- TLB: ppl_tlb_flush_o = 1 for exactly one cycle. Next is DONE.
- DONE: done_o[gnt_q] = 1 for one cycle. Next is IDLE. An arbitration in the following IDLE cycle sees the requester's deasserted valid.
- All flush outputs and done_o decode from registered state only (Moore). They carry no combinational path from inputs.
- Changes to req_*_i after grant are ignored until the next grant.
- A requester dropping valid before done is a protocol violation. The sequence still completes and pulses done_o.
- ppl_dcache_flush_ack_i outside DC is ignored.
- Reset asserted mid-sequence:
  - State → IDLE, rr_q → 0, all outputs → 0 asynchronously.
  - An in-flight D$ flush request drops. The D$ tolerates abandonment.

## Timing
- Reset values: done_o = 0, err_o = 0, busy_o = 0, all three flush outputs = 0.
- Latency from req_valid_i sampled high in IDLE (cycle 0):
  - First flush output asserts at cycle 1.
  - busy_o rises at cycle 1.
- DC only, ack at cycle k (k ≥ 1): DONE at cycle k+1, done_o at cycle k+1.
- ic+tlb only: IC at 1, TLB at 2, done_o at 3.
- No type bits: done_o at cycle 1.
- Back-to-back requests: minimum gap from done_o to the next grant's first output is 2 cycles (IDLE occupies 1 cycle).
- Simultaneous requests: rr_q priority, so each requester is granted at most once before every other pending requester is served.

## Configuration
- SY_FLUSH_TIMEOUT_EN defined:
  - A counter of width $clog2(TO_CYC) clears on DC entry and increments each DC cycle without ack.
  - When it reaches TO_CYC-1 with no ack, the block goes to DONE and sets err_o = 1 with done_o. Remaining IC/TLB steps are skipped.
  - Ack in the same cycle as the terminal count wins: normal completion, err_o = 0.
- SY_FLUSH_TIMEOUT_EN undefined: no counter is built. DC waits indefinitely and err_o is tied 0.

## Test plan
- Reset, then req_valid_i=01 with dc=1 and ack at cycle 4:
  - Required: ppl_dcache_flush_o high cycles 1–4, done_o=01 at cycle 5, err_o=0.
- req 0 with dc=ic=tlb=1 and ack at cycle 2:
  - Required: dcache high 1–2, icache pulse at 3, tlb pulse at 4, done_o=01 at 5.
- Both requesters valid continuously (ic only), rr_q=0:
  - Required grants alternate 0,1,0. done_o pulses every 3 cycles: 01, 10, 01.
- Request with no type bits:
  - Required: done_o at cycle 1, no flush output toggles.
- Timeout build, TO_CYC=8, ack never arrives:
  - Required: dcache high for 8 cycles, then done_o and err_o together. A later ack in IDLE is ignored.
- rst_i driven low during DC at cycle 3:
  - Required: all outputs 0 immediately. After release, a new request is granted normally with rr_q=0.
